pio_in_edge_capture: RTL

Parametrised Avalon-MM input PIO that supersedes the fixed 8-bit switch reader. Each bit passes through a multi-stage synchroniser, then per-bit edge detection into a sticky edge-capture register, with a maskable level interrupt. The block sits on the system interconnect as a slave serving switches, buttons and status lines to the soft CPU.

---
 rtl/pio_in_edge_capture.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: parametrised Avalon-MM input PIO with a synchroniser,
// per-bit edge detection into a sticky edge-capture register, and a maskable
// level interrupt.
//
// Optional build macro: DEBOUNCE_EN inserts a per-bit stable-count debouncer
// between the synchroniser and the edge logic.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect  slave select, qualifies writes only
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle latency
//   irq         level interrupt, active high
module pio_in_edge_capture #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
   localparam int unsigned PRIME_W   = 3;
   localparam int unsigned CNT_W     = 16;

   // Elaboration-time guard on the legal parameter ranges
   if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_params
      $error("pio_in_edge_capture: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  s;
   logic [WIDTH-1:0]                  v;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  mask_q;
   logic [WIDTH-1:0]                  edgecap_q;
   logic [WIDTH-1:0]                  ev;
   logic [WIDTH-1:0]                  set_c;
   logic [WIDTH-1:0]                  clr_c;
   logic [PRIME_W-1:0]                prime_q;
   logic                              primed;
   logic                              wr_en;
   logic [31:0]                       rd_nxt;
   logic                              unused_wdata;

   // Upper writedata bits are don't-care for narrow instances
   assign unused_wdata = ^writedata;

   // Synchroniser chain, stage 0 samples the pins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
   logic [WIDTH-1:0][CNT_W-1:0] db_cnt_q;
   logic [WIDTH-1:0]            stable_q;

   // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q <= '0;
         stable_q <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (s[i] != stable_q[i]) begin
               if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  stable_q[i] <= s[i];
                  db_cnt_q[i] <= '0;
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   assign v = stable_q;
`else
   assign v = s;
`endif

   // Edge event selection
   if (EDGE_TYPE == 0) begin : g_rise
      assign ev = v & ~prev_q;
   end else if (EDGE_TYPE == 1) begin : g_fall
      assign ev = ~v & prev_q;
   end else begin : g_any
      assign ev = v ^ prev_q;
   end

   // Prime window: hide the reset-release transient of the synchroniser
   assign primed = (prime_q == PRIME_W'(PRIME_MAX));

   assign wr_en = chipselect & ~write_n;
   assign set_c = primed ? ev : '0;
   assign clr_c = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // Read mux; reserved and unused upper bits read as zero
   always_comb begin
      rd_nxt = '0;
      case (address)
         2'd0:    rd_nxt = 32'(v);
         2'd2:    rd_nxt = 32'(mask_q);
         2'd3:    rd_nxt = 32'(edgecap_q);
         default: rd_nxt = '0;
      endcase
   end

   // State registers; a set on the same cycle as a clear wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q    <= '0;
         mask_q    <= '0;
         edgecap_q <= '0;
         prime_q   <= '0;
         readdata  <= '0;
         irq       <= 1'b0;
      end else begin
         prev_q    <= v;
         edgecap_q <= (edgecap_q & ~clr_c) | set_c;
         readdata  <= rd_nxt;
         irq       <= |(edgecap_q & mask_q);
         if (!primed)
            prime_q <= prime_q + PRIME_W'(1);
         if (wr_en && address == 2'd2)
            mask_q <= writedata[WIDTH-1:0];
      end
   end

endmodule
